// File: rtl/demux_steer_ctrl_pkg.sv
// Shared definitions for the demux steering controller and the demux bench.
//   steer_state_e : sequencer state encoding (RUN / DRAIN / GAP)
//   GAP_CNT_W     : width of the idle-gap counter (GAP_CYC is at most 7)
//   clamp_sel()   : limits a requested select to the highest legal output
package demux_steer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GAP   = 2'd2
    } steer_state_e;

    localparam int unsigned GAP_CNT_W = 3;

    // Selects are at most 2 bits wide in practice; 8 bits leaves headroom.
    function automatic logic [7:0] clamp_sel(input logic [7:0] sel, input logic [7:0] max_sel);
        return (sel > max_sel) ? max_sel : sel;
    endfunction

endpackage

// File: rtl/demux_steer_ctrl_slice.sv
// One-beat holding register for the demux data word and its select.
// Data and select are captured together so the demux sees them change on
// the same edge.
//   clk, rst  : clock, synchronous active-high reset
//   load_i    : capture data_i/sel_i and mark the beat valid
//   ready_i   : downstream consumes the held beat this cycle
//   data_i    : word to hold          sel_i   : select to hold
//   data_o    : held word             sel_o   : held select
//   valid_o   : a beat is held
module steer_reg_slice #(
    parameter int unsigned DATA_W = 2,
    parameter int unsigned SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic [DATA_W-1:0] data_o,
    output logic [SEL_W-1:0]  sel_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] data_q;
    logic [SEL_W-1:0]  sel_q;
    logic              valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            sel_q   <= sel_i;
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            // Data and select keep their last values after a drain.
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign sel_o   = sel_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/demux_steer_ctrl.sv
// Sequencer and register slice feeding a NUM_OUT-way demux. Beats are
// grouped into bursts of BURST_LEN; each burst goes to one output, chosen
// round-robin (mode=1) or from fixed_sel (mode=0, clamped). When the select
// changes between bursts, input is stalled until the held beat leaves and
// GAP_CYC idle cycles have passed on the demux input.
//   clk, rst             : clock, synchronous active-high reset
//   in_data/valid/ready  : upstream valid/ready stream
//   mode, fixed_sel      : steering policy, sampled at burst boundaries
//   out_data/sel/valid   : registered beat and select to the demux
//   out_ready            : downstream consumes the held beat
//   burst_done           : pulse, last beat of a burst was accepted
//   beat_cnt             : beats accepted in the current burst
module demux_steer_ctrl
    import demux_steer_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W    = 2,
    parameter int unsigned NUM_OUT   = 2,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned GAP_CYC   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_W-1:0]              in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           mode,
    input  logic [SEL_W-1:0]               fixed_sel,
    output logic [DATA_W-1:0]              out_data,
    output logic [SEL_W-1:0]               out_sel,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           burst_done,
    output logic [$clog2(BURST_LEN+1)-1:0] beat_cnt
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [SEL_W-1:0] SEL_MAX   = SEL_W'(NUM_OUT - 1);
    // The cycle in which the held beat drains already has in_ready low, so
    // the GAP state covers the remaining GAP_CYC-1 stall cycles. The demux
    // input then sees exactly GAP_CYC cycles with out_valid low.
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
        (GAP_CYC >= 2) ? GAP_CNT_W'(GAP_CYC - 2) : '0;

    steer_state_e         state_q;
    logic [SEL_W-1:0]     cur_sel_q;
    logic [SEL_W-1:0]     nxt_sel_q;
    logic [CNT_W-1:0]     beat_cnt_q;
    logic [GAP_CNT_W-1:0] gap_q;
    logic                 burst_done_q;

    logic [SEL_W-1:0]     fix_sel;
    logic [SEL_W-1:0]     rr_sel;
    logic [SEL_W-1:0]     nxt_sel;
    logic                 slice_valid;
    logic                 accept;
    logic                 last_beat;

    always_comb begin
        fix_sel = SEL_W'(clamp_sel(8'(fixed_sel), 8'(NUM_OUT - 1)));
        rr_sel  = (cur_sel_q == SEL_MAX) ? '0 : cur_sel_q + SEL_W'(1);
        nxt_sel = mode ? rr_sel : fix_sel;
    end

    // Gated by rst so nothing is taken in the reset cycle itself.
    assign in_ready  = !rst && (state_q == ST_RUN) && (!slice_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_cnt_q == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            // Policy is sampled on every reset edge; the last one wins.
            cur_sel_q    <= mode ? '0 : fix_sel;
            nxt_sel_q    <= '0;
            beat_cnt_q   <= '0;
            gap_q        <= '0;
            burst_done_q <= 1'b0;
        end else begin
            burst_done_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        if (last_beat) begin
                            burst_done_q <= 1'b1;
                            beat_cnt_q   <= '0;
                            if ((nxt_sel != cur_sel_q) && (GAP_CYC != 0)) begin
                                nxt_sel_q <= nxt_sel;
                                state_q   <= ST_DRAIN;
                            end else begin
                                cur_sel_q <= nxt_sel;
                            end
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave once the held beat is gone or going this cycle.
                    if (!slice_valid || out_ready) begin
                        if (GAP_CYC <= 1) begin
                            cur_sel_q <= nxt_sel_q;
                            state_q   <= ST_RUN;
                        end else begin
                            gap_q   <= GAP_LOAD;
                            state_q <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        cur_sel_q <= nxt_sel_q;
                        state_q   <= ST_RUN;
                    end else begin
                        gap_q <= gap_q - GAP_CNT_W'(1);
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    steer_reg_slice #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_slice (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .ready_i (out_ready),
        .data_i  (in_data),
        .sel_i   (cur_sel_q),
        .data_o  (out_data),
        .sel_o   (out_sel),
        .valid_o (slice_valid)
    );

    assign out_valid  = slice_valid;
    assign burst_done = burst_done_q;
    assign beat_cnt   = beat_cnt_q;

endmodule

// File: doc/demux_steer_ctrl.md
# demux_steer_ctrl

Sequencer and one-beat register slice that feeds the 2-output demultiplexer stage. It accepts a valid/ready stream of small data words and presents each word on `out_data` with a registered `out_sel`, so the two are stable together. It steers fixed-length bursts to outputs in round-robin order, or to a fixed output, and inserts a programmable idle gap whenever the select changes so the downstream demux never switches with live data on its input.

## Interface
Parameters:
- `DATA_W`, default 2: data word width, equal to the demux data input width.
- `NUM_OUT`, default 2: number of demux outputs; legal range 2..4.
- `SEL_W`, default 2: select width, equal to the demux select width.
- `BURST_LEN`, default 4: beats per burst; must be ≥ 1.
- `GAP_CYC`, default 1: idle cycles inserted on a select change; legal range 0..7.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_data`  in  DATA_W  upstream word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the block accepts a beat this cycle.
- `mode`  in  1  1 = round-robin bursts; 0 = fixed output.
- `fixed_sel`  in  SEL_W  target output when `mode`=0.
- `out_data`  out  DATA_W  to the demux data input.
- `out_sel`  out  SEL_W  to the demux select input.
- `out_valid`  out  1  `out_data`/`out_sel` are valid.
- `out_ready`  in  1  downstream consumes the held beat.
- `burst_done`  out  1  one-cycle pulse when the last beat of a burst is accepted.
- `beat_cnt`  out  $clog2(BURST_LEN+1)  beats accepted in the current burst.

## Operation
- A beat is accepted when `in_valid && in_ready`. A beat is drained when `out_valid && out_ready`.
- `in_ready` = (state==RUN) && (!out_valid || out_ready). A beat can be drained and a new one accepted in the same cycle.
- On accept: `out_data`←`in_data`, `out_sel`←`cur_sel`, `out_valid`←1, `beat_cnt`++.
- On drain with no accept: `out_valid`←0. `out_data` and `out_sel` keep their values.
- `cur_sel` is internal:
  - `mode`=1: it advances at each burst boundary, running 0,1,…,NUM_OUT-1 and wrapping to 0.
  - `mode`=0: it loads `fixed_sel`, clamped to NUM_OUT-1 if larger.
- `mode` and `fixed_sel` are sampled only at burst boundaries and on leaving reset. Changes made mid-burst take effect at the next burst.
- States:
  - RUN: normal accept/drain. When the last beat of a burst is accepted, `burst_done` pulses and `beat_cnt`←0. If the next `cur_sel` differs from the current one and GAP_CYC>0, go to DRAIN; otherwise stay in RUN.
  - DRAIN: `in_ready`=0. Wait until `out_valid`=0, then load the gap counter with GAP_CYC and go to GAP.
  - GAP: `in_ready`=0. Decrement each cycle; at 0, update `cur_sel` and return to RUN.
- When the select does not change (fixed mode with the same target, or NUM_OUT wrap landing on the same value), there is no gap.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_sel`=0, `in_ready`=0 in the reset cycle, `burst_done`=0, `beat_cnt`=0, state=RUN, `cur_sel` loaded from mode/`fixed_sel` at the first post-reset edge.
- Latency is 1 cycle from accept to `out_valid`. Throughput is 1 beat per cycle within a burst.
- Switching penalty per select change = (cycles to drain the held beat) + GAP_CYC, during which `in_ready` is low.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_sel` hold stable and `in_ready`=0.
- Reset asserted mid-burst or mid-gap: the next cycle matches the reset values. The held beat is discarded and the burst count restarts.
- BURST_LEN=1: every beat is a burst boundary and `burst_done` pulses on every accept.

## Structure
- Shared package/header holds the state encoding (RUN, DRAIN, GAP) and the sel-clamp function, also used by the demux bench.
- One natural sub-module, `steer_reg_slice`: the one-beat data/sel holding register with valid/ready. The FSM, burst counter and gap counter live in the top module.

## Test plan
- Reset then stream 8 beats 0,1,2,3,0,1,2,3 with `mode`=1, `out_ready`=1, defaults → beats 0–3 with `out_sel`=0, then a 1-cycle `in_ready` gap, then beats 4–7 with `out_sel`=1; `burst_done` pulses on beat 3 and beat 7.
- `mode`=0, `fixed_sel`=3 with NUM_OUT=2 → `out_sel`=1 on every beat and no gaps across 3 bursts.
- Hold `out_ready`=0 for 5 cycles after beat 2 → `out_data`, `out_sel` and `out_valid` stay stable, `in_ready`=0, and no beat is lost or duplicated.
- Change `mode` from 1 to 0 after beat 1 of a burst → the burst completes on the current select; the new fixed select applies to the following burst.
- Assert `rst` during GAP → the next cycle shows `out_valid`=0, `beat_cnt`=0, `out_sel`=0, and the stream restarts cleanly.
- GAP_CYC=3, BURST_LEN=1, round-robin → every accepted beat is followed by 3 idle cycles, and `out_sel` alternates 0,1,0,1.
